// File: rtl/prog_sequencer_if.sv
// rtl/prog_sequencer_if.sv - request/core handshake bundle for prog_sequencer
interface prog_sequencer_if;
  logic       req;
  logic       core_halt;
  logic       core_init;
  logic       core_run;
  logic [7:0] start_pc;
  logic [1:0] prog_id;
  logic       ack;
  logic       timeout;

  modport master (
    input  req, core_halt,
    output core_init, core_run, start_pc, prog_id, ack, timeout
  );

  modport slave (
    output req, core_halt,
    input  core_init, core_run, start_pc, prog_id, ack, timeout
  );
endinterface

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - launches three core programs in turn with a run watchdog
module prog_sequencer #(
  parameter logic [7:0]  PC0 = 8'd0,
  parameter logic [7:0]  PC1 = 8'd64,
  parameter logic [7:0]  PC2 = 8'd128,
  parameter logic [15:0] TMO = 16'd50000
) (
  input  logic CLK,
  input  logic start,
  prog_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        req_block_q, req_block_d;
  logic [1:0]  prog_id_q, prog_id_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        req_edge;

  always_comb begin
    state_d     = state_q;
    req_d       = bus.req;
    // A req held high across reset release must drop once before it can launch.
    req_block_d = req_block_q & bus.req;
    prog_id_d   = prog_id_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    req_edge    = bus.req & ~req_q & ~req_block_q;

    case (state_q)
      IDLE, DONE: begin
        if (req_edge) begin
          state_d   = LOAD;
          timeout_d = 1'b0;
        end
      end
      LOAD: begin
        cnt_d   = 16'd0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.core_halt || cnt_q == TMO - 16'd1) begin
          state_d   = DONE;
          timeout_d = ~bus.core_halt;
          prog_id_d = (prog_id_q >= 2'd2) ? 2'd0 : prog_id_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      req_block_q <= bus.req;
      prog_id_q   <= 2'd0;
      cnt_q       <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_block_q <= req_block_d;
      prog_id_q   <= prog_id_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    bus.core_init = (state_q == LOAD);
    bus.core_run  = (state_q == RUN);
    bus.ack       = (state_q == DONE);
    bus.timeout   = timeout_q;
    bus.prog_id   = prog_id_q;
    case (prog_id_q)
      2'd1:    bus.start_pc = PC1;
      2'd2:    bus.start_pc = PC2;
      default: bus.start_pc = PC0;
    endcase
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter PC0, default 8'd0, start PC of program 1.
REQ-002 SHALL have parameter PC1, default 8'd64, start PC of program 2.
REQ-003 SHALL have parameter PC2, default 8'd128, start PC of program 3.
REQ-004 SHALL have parameter TMO, default 16'd50000, maximum run cycles before abort.
REQ-005 SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port start, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port req, input, 1 bit, level request from the bench; a rising edge starts the next program.
REQ-008 SHALL have port core_halt, input, 1 bit, core executed its halt instruction.
REQ-009 SHALL have port core_init, output, 1 bit, one-cycle pulse telling the core to load start_pc.
REQ-010 SHALL have port core_run, output, 1 bit, enables core instruction fetch/execute.
REQ-011 SHALL have port start_pc, output, 8 bits, PC selected for the current program.
REQ-012 SHALL have port prog_id, output, 2 bits, index of the next/current program: 0, 1 or 2.
REQ-013 SHALL have port ack, output, 1 bit, program finished; drives the bench's ack.
REQ-014 SHALL have port timeout, output, 1 bit, last program aborted by the watchdog.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-016 SHALL register req each cycle and detect a rising edge as req=1 with previous req=0.
REQ-017 SHALL, in IDLE or DONE, go to LOAD on the cycle after a req rising edge is sampled.
REQ-018 SHALL ignore req edges in LOAD and RUN; they are not queued.
REQ-019 SHALL drive core_init=1 only in LOAD, with start_pc = PC0/PC1/PC2 selected by prog_id, then go to RUN.
REQ-020 SHALL drive start_pc from prog_id combinationally in every state.
REQ-021 SHALL drive core_run=1 only in RUN.
REQ-022 SHALL, on sampling core_halt=1 in RUN, go to DONE next cycle; core_halt is ignored in other states.
REQ-023 SHALL clear a 16-bit run counter in LOAD and increment it each RUN cycle.
REQ-024 SHALL, when the counter equals TMO-1 in RUN and core_halt=0, go to DONE and set timeout=1.
REQ-025 SHALL treat core_halt=1 on the counter-expiry cycle as normal completion, with timeout=0.
REQ-026 SHALL hold timeout until the next LOAD, which clears it.
REQ-027 SHALL drive ack=1 throughout DONE; ack SHALL drop on the LOAD cycle following the next req edge.
REQ-028 SHALL, on entry to DONE, advance prog_id 0->1->2->0; the wrap after program 3 is required.
REQ-029 SHALL, with prog_id=3 (unreachable), select PC0 and wrap to 0 on advance.
REQ-030 SHALL give a latency of 2 cycles from the req edge being sampled to core_run=1, and 1 cycle from core_halt sampled to ack=1.

Reset
REQ-031 SHALL, while start=1 at a rising CLK edge, force state IDLE, prog_id=0, counter=0, timeout=0 and registered req=0.
REQ-032 SHALL hold outputs ack=0, core_init=0 and core_run=0 during reset, with start_pc=PC0.
REQ-033 SHALL, if start is asserted mid-RUN, deassert core_run on the next edge and restart from program 1; no ack is produced.
REQ-034 SHALL, if req is held high through reset release, not start a program; a fresh 0->1 edge is required.

Verification
REQ-035 SHALL verify basic run: reset 2 cycles; req pulse; core_halt after 20 cycles -> core_init for exactly 1 cycle with start_pc=0; core_run for 20 cycles; ack=1; prog_id=1.
REQ-036 SHALL verify three-program sequence: three req/halt rounds -> start_pc 0, 64, 128 in turn; prog_id ends at 0; ack drops on each new LOAD.
REQ-037 SHALL verify the watchdog: TMO=100, core_halt never asserted -> core_run high exactly 100 cycles, then ack=1 and timeout=1; timeout clears on the next LOAD.
REQ-038 SHALL verify ignored requests: req pulse during RUN -> no second LOAD after halt; ack stays 1 until a new req edge.
REQ-039 SHALL verify mid-run reset: start=1 during RUN of program 2 -> core_run=0, prog_id=0, ack=0; the next req loads start_pc=0.
REQ-040 SHALL verify the halt/expiry tie: core_halt=1 on counter=TMO-1 -> ack=1 with timeout=0.
